// File: rtl/cam_assoc_pkg.sv
// cam_assoc_pkg: shared types and width helpers for the N-way associative
// lookup store (cam_assoc_nway) and its victim selector.
//   cam_state_e  : walk/operate FSM encoding
//   cam_idx_w    : set index width from SETS
//   cam_tag_w    : tag width from ADDR_W and SETS
//   cam_way_w    : way index width from WAYS (never below 1 bit)
//   cam_key_t    : default-geometry index/tag split of a lookup key
package cam_assoc_pkg;

  typedef enum logic {
    CAM_FLUSH = 1'b0,
    CAM_IDLE  = 1'b1
  } cam_state_e;

  function automatic int unsigned cam_idx_w(input int unsigned sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int unsigned cam_tag_w(input int unsigned addr_w,
                                            input int unsigned sets);
    return addr_w - cam_idx_w(sets);
  endfunction

  function automatic int unsigned cam_way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Key split for the default geometry (ADDR_W=20, SETS=2048).
  localparam int unsigned CAM_DEF_ADDR_W = 20;
  localparam int unsigned CAM_DEF_SETS   = 2048;

  typedef struct packed {
    logic [cam_tag_w(CAM_DEF_ADDR_W, CAM_DEF_SETS)-1:0] tag;
    logic [cam_idx_w(CAM_DEF_SETS)-1:0]                 idx;
  } cam_key_t;

endpackage

// File: rtl/cam_assoc_victim_sel.sv
// cam_assoc_victim_sel: combinational way chooser for the write path.
//   i_valid : per-way valid bits of the addressed set
//   i_hit   : per-way tag-match (valid && tag equal) bits
//   i_ptr   : round-robin victim pointer of the set
//   o_way   : way to write
//   o_alloc : 1 = allocate (new entry), 0 = update of an existing entry
// Priority: lowest hitting way (update), else lowest invalid way, else i_ptr.
module cam_assoc_victim_sel
  import cam_assoc_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAYS-1:0]  i_hit,
  input  logic [WAY_W-1:0] i_ptr,
  output logic [WAY_W-1:0] o_way,
  output logic             o_alloc
);

  logic             w_hit_found;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_free_found;
  logic [WAY_W-1:0] w_free_way;

  always_comb begin
    w_hit_found = 1'b0;
    w_hit_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_hit_found && i_hit[w]) begin
        w_hit_found = 1'b1;
        w_hit_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_free_found && !i_valid[w]) begin
        w_free_found = 1'b1;
        w_free_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    o_alloc = !w_hit_found;
    if (w_hit_found)       o_way = w_hit_way;
    else if (w_free_found) o_way = w_free_way;
    else                   o_way = i_ptr;
  end

endmodule

// File: rtl/cam_assoc_nway.sv
// cam_assoc_nway: N-way set-associative tag/data store with PORTS registered
// lookup ports, one write (refill) port, per-set round-robin replacement and
// a set-walking flush engine (runs after reset and on flush_req).
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush_req         : pulse, invalidate all entries (ignored while walking)
//   flush_busy        : high while the flush walk runs
//   wr_valid/wr_ready : write handshake; wr_addr key, wr_data payload
//   lu_valid/lu_addr  : per-port lookup request (lu_addr packed PORTS x ADDR_W)
//   rs_valid/rs_hit   : per-port result, one cycle after lu_valid
//   rs_data/rs_way    : hit payload / way (packed per port), 0 on miss
// Optional: define CAM_ASSOC_WR_BYPASS_EN to forward an accepted write to a
// same-cycle lookup of the identical key.
module cam_assoc_nway
  import cam_assoc_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 2048,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PORTS  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_req,
  output logic                              flush_busy,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic [PORTS-1:0]                  lu_valid,
  input  logic [PORTS*ADDR_W-1:0]           lu_addr,
  output logic [PORTS-1:0]                  rs_valid,
  output logic [PORTS-1:0]                  rs_hit,
  output logic [PORTS*DATA_W-1:0]           rs_data,
  output logic [PORTS*cam_way_w(WAYS)-1:0]  rs_way
);

  localparam int unsigned IDX_W = cam_idx_w(SETS);
  localparam int unsigned TAG_W = cam_tag_w(ADDR_W, SETS);
  localparam int unsigned WAY_W = cam_way_w(WAYS);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [WAY_W-1:0] way_t;

  // Storage: never reset, cleared set-by-set by the flush walk.
  tag_t              r_tag   [WAYS][SETS];
  logic [DATA_W-1:0] r_data  [WAYS][SETS];
  logic              r_valid [WAYS][SETS];
  way_t              r_ptr   [SETS];

  cam_state_e r_state;
  idx_t       r_walk_idx;

  // FSM: flush walk and idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CAM_FLUSH;
      r_walk_idx <= '0;
    end else begin
      case (r_state)
        CAM_FLUSH: begin
          r_walk_idx <= r_walk_idx + 1'b1;
          if (r_walk_idx == idx_t'(SETS - 1)) r_state <= CAM_IDLE;
        end
        CAM_IDLE: begin
          if (flush_req) begin
            r_state    <= CAM_FLUSH;
            r_walk_idx <= '0;
          end
        end
        default: begin
          r_state    <= CAM_FLUSH;
          r_walk_idx <= '0;
        end
      endcase
    end
  end

  assign flush_busy = (r_state == CAM_FLUSH);
  assign wr_ready   = !flush_busy && !flush_req;

  // Write path
  idx_t            w_wr_idx;
  tag_t            w_wr_tag;
  logic [WAYS-1:0] w_wr_vld_vec;
  logic [WAYS-1:0] w_wr_hit_vec;
  way_t            w_ptr_cur;
  way_t            w_ptr_next;
  way_t            w_sel_way;
  logic            w_sel_alloc;
  logic            w_wr_fire;

  assign w_wr_idx  = wr_addr[IDX_W-1:0];
  assign w_wr_tag  = wr_addr[ADDR_W-1:IDX_W];
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_ptr_cur = r_ptr[w_wr_idx];
  assign w_ptr_next = (WAYS > 1) ? w_ptr_cur + way_t'(1) : '0;

  always_comb begin
    w_wr_vld_vec = '0;
    w_wr_hit_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_wr_vld_vec[w] = r_valid[w][w_wr_idx];
      w_wr_hit_vec[w] = r_valid[w][w_wr_idx] && (r_tag[w][w_wr_idx] == w_wr_tag);
    end
  end

  cam_assoc_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .i_valid (w_wr_vld_vec),
    .i_hit   (w_wr_hit_vec),
    .i_ptr   (w_ptr_cur),
    .o_way   (w_sel_way),
    .o_alloc (w_sel_alloc)
  );

  always_ff @(posedge clk) begin
    if (r_state == CAM_FLUSH) begin
      for (int unsigned w = 0; w < WAYS; w++) r_valid[w][r_walk_idx] <= 1'b0;
      r_ptr[r_walk_idx] <= '0;
    end else if (w_wr_fire) begin
      r_tag[w_sel_way][w_wr_idx]   <= w_wr_tag;
      r_data[w_sel_way][w_wr_idx]  <= wr_data;
      r_valid[w_sel_way][w_wr_idx] <= 1'b1;
      if (w_sel_alloc) r_ptr[w_wr_idx] <= w_ptr_next;
    end
  end

  // Lookup ports: combinational match on pre-write contents, then registered
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    idx_t              w_idx;
    tag_t              w_tag;
    logic              w_hit;
    logic [DATA_W-1:0] w_dat;
    way_t              w_way;
    logic              r_vld;
    logic              r_hit;
    logic [DATA_W-1:0] r_dat;
    way_t              r_way;

    assign w_idx = lu_addr[p*ADDR_W +: IDX_W];
    assign w_tag = lu_addr[p*ADDR_W+IDX_W +: TAG_W];

    always_comb begin
      w_hit = 1'b0;
      w_dat = '0;
      w_way = '0;
      if (r_state == CAM_IDLE && !flush_req) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (!w_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
            w_hit = 1'b1;
            w_dat = r_data[w][w_idx];
            w_way = way_t'(w);
          end
        end
      end
`ifdef CAM_ASSOC_WR_BYPASS_EN
      if (w_wr_fire && (lu_addr[p*ADDR_W +: ADDR_W] == wr_addr)) begin
        w_hit = 1'b1;
        w_dat = wr_data;
        w_way = w_sel_way;
      end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_hit <= 1'b0;
        r_dat <= '0;
        r_way <= '0;
      end else begin
        r_vld <= lu_valid[p];
        r_hit <= lu_valid[p] && w_hit;
        r_dat <= lu_valid[p] ? w_dat : '0;
        r_way <= lu_valid[p] ? w_way : '0;
      end
    end

    assign rs_valid[p]                = r_vld;
    assign rs_hit[p]                  = r_hit;
    assign rs_data[p*DATA_W +: DATA_W] = r_dat;
    assign rs_way[p*WAY_W +: WAY_W]    = r_way;
  end

endmodule
